// File: rtl/irl_bucket_mem.sv
// irl_bucket_mem: per-flow token-bucket state RAM (1R1W) with a deferred
// auxiliary writer, read forwarding and a power-up / on-demand clear sweep.
//
// state    | meaning
// ST_IDLE  | normal traffic: app writes, aux drain, reads from RAM/forwarding
// ST_SWEEP | writing INIT_VALUE to every entry, one address per cycle
module irl_bucket_mem #(
  parameter int unsigned              DATA_NBITS  = 36,
  parameter int unsigned              DEPTH_NBITS = 10,
  parameter logic [DATA_NBITS-1:0]    INIT_VALUE  = '0,
  parameter bit                       FWD_EN      = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear_req,
  output logic                   o_clear_busy,
  input  logic                   i_app_rd,
  input  logic [DEPTH_NBITS-1:0] i_app_raddr,
  output logic                   o_app_ack,
  output logic [DATA_NBITS-1:0]  o_app_rdata,
  input  logic                   i_app_wr,
  input  logic [DEPTH_NBITS-1:0] i_app_waddr,
  input  logic [DATA_NBITS-1:0]  i_app_wdata,
  input  logic                   i_aux_wr,
  input  logic [DEPTH_NBITS-1:0] i_aux_waddr,
  input  logic [DATA_NBITS-1:0]  i_aux_wdata,
  output logic                   o_aux_ready,
  output logic                   o_err_drop
);

  localparam int unsigned DEPTH = 2 ** DEPTH_NBITS;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_clear_start;
  logic                   w_busy;
  logic                   w_sweep_last;
  logic [DEPTH_NBITS-1:0] r_sweep_addr;

  logic                   r_pend_vld;
  logic [DEPTH_NBITS-1:0] r_pend_addr;
  logic [DATA_NBITS-1:0]  r_pend_data;
  logic                   w_aux_ready;
  logic                   w_aux_take;
  logic                   w_drain;
  logic                   w_supersede;
  logic                   w_drop;
  logic                   r_err_drop;

  logic [DATA_NBITS-1:0]  r_mem [DEPTH];
  logic                   w_ram_we;
  logic [DEPTH_NBITS-1:0] w_ram_waddr;
  logic [DATA_NBITS-1:0]  w_ram_wdata;
  logic [DATA_NBITS-1:0]  r_ram_q;

  logic                   r_ack;
  logic                   r_rd_init;
  logic                   r_hit_app;
  logic                   r_hit_pend;
  logic [DATA_NBITS-1:0]  r_app_data_q;
  logic [DATA_NBITS-1:0]  r_pend_data_q;
  logic [DATA_NBITS-1:0]  w_rdata;

  assign w_busy       = (r_state == ST_SWEEP);
  assign w_sweep_last = &r_sweep_addr;

  // Reset parks the FSM in ST_SWEEP at address 0 so the sweep begins as rst falls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_SWEEP;
      r_sweep_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear_start) begin
        r_sweep_addr <= '0;
      end else if (w_busy) begin
        r_sweep_addr <= r_sweep_addr + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clear_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_clear_req) begin
          w_state_nxt   = ST_SWEEP;
          w_clear_start = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (w_sweep_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_SWEEP;
    endcase
  end

  assign w_aux_ready = ~r_pend_vld & ~w_busy;
  assign w_aux_take  = i_aux_wr & w_aux_ready;
  assign w_drain     = r_pend_vld & ~i_app_wr & ~w_busy;
  assign w_supersede = r_pend_vld & i_app_wr & ~w_busy & (i_app_waddr == r_pend_addr);
  assign w_drop      = (i_aux_wr & ~w_aux_ready) | (i_app_wr & w_busy);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend_vld <= 1'b0;
      r_err_drop <= 1'b0;
    end else begin
      if (w_clear_start) begin
        r_pend_vld <= 1'b0;
      end else if (w_aux_take) begin
        r_pend_vld <= 1'b1;
      end else if (w_drain | w_supersede) begin
        r_pend_vld <= 1'b0;
      end
      // A drop coinciding with the sweep start is still reported.
      if (w_clear_start) begin
        r_err_drop <= w_drop;
      end else if (w_drop) begin
        r_err_drop <= 1'b1;
      end
    end
    if (w_aux_take) begin
      r_pend_addr <= i_aux_waddr;
      r_pend_data <= i_aux_wdata;
    end
  end

  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = i_app_waddr;
    w_ram_wdata = i_app_wdata;
    if (w_busy) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = r_sweep_addr;
      w_ram_wdata = INIT_VALUE;
    end else if (i_app_wr) begin
      w_ram_we    = 1'b1;
    end else if (r_pend_vld) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = r_pend_addr;
      w_ram_wdata = r_pend_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_waddr] <= w_ram_wdata;
    end
    if (i_app_rd) begin
      r_ram_q <= r_mem[i_app_raddr];
    end
  end

  // Forwarding decisions are captured alongside the RAM read and resolved next cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= i_app_rd;
    end
    if (i_app_rd) begin
      r_rd_init     <= w_busy;
      r_hit_app     <= FWD_EN & i_app_wr & (i_app_waddr == i_app_raddr);
      r_hit_pend    <= FWD_EN & r_pend_vld & (r_pend_addr == i_app_raddr);
      r_app_data_q  <= i_app_wdata;
      r_pend_data_q <= r_pend_data;
    end
  end

  always_comb begin
    w_rdata = r_ram_q;
    if (r_rd_init) begin
      w_rdata = INIT_VALUE;
    end else if (r_hit_app) begin
      w_rdata = r_app_data_q;
    end else if (r_hit_pend) begin
      w_rdata = r_pend_data_q;
    end
  end

  assign o_clear_busy = w_busy;
  assign o_aux_ready  = w_aux_ready;
  assign o_err_drop   = r_err_drop;
  assign o_app_ack    = r_ack;
  assign o_app_rdata  = w_rdata;

endmodule
